// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS word registers on the core's
// data bus, a small byte FIFO, and a start/data/stop serialiser with a baud counter.
module mmio_uart_tx #(
    parameter logic [31:0] BASE   = 32'h804,
    parameter int          CLKDIV = 16,
    parameter int          DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        Hit,
    output logic        tx
);

    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              BW         = $clog2(CLKDIV);
    localparam logic [31:0]     STATUS_ADR = BASE + 32'd4;
    localparam logic [BW-1:0]   BAUD_LOAD  = BW'(CLKDIV - 1);
    localparam logic [3:0]      DEPTH_CNT  = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_reg,  state_next;
    logic [BW-1:0]   baud_reg,   baud_next;
    logic [2:0]      bit_reg,    bit_next;
    logic [7:0]      shift_reg,  shift_next;
    logic            tx_reg,     tx_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [3:0]      count_reg,  count_next;
    logic            ovf_reg,    ovf_next;

    logic [7:0]      mem [DEPTH];

    logic            hit_data;
    logic            hit_status;
    logic            full;
    logic            empty;
    logic            busy;
    logic            push_attempt;
    logic            push;
    logic            pop;
    logic            clear_ovf;
    logic            unused_inputs;

    // Loads are side-effect free, so MemtoReg and the upper store bits are never consumed.
    assign unused_inputs = ^{MemtoReg, WriteData[31:8]};

    assign hit_data   = (DataAdr == BASE);
    assign hit_status = (DataAdr == STATUS_ADR);
    assign Hit        = hit_data | hit_status;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == 4'd0);
    assign busy  = (state_reg != IDLE);

    assign push_attempt = MemWrite & hit_data;
    assign push         = push_attempt & ~full;
    assign clear_ovf    = MemWrite & hit_status & WriteData[3];

    always_comb begin
        RdData = 32'h0;
        if (hit_status) begin
            RdData = {24'b0, count_reg, ovf_reg, busy, empty, full};
        end
    end

    assign tx = tx_reg;

    // FIFO storage has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= WriteData[7:0];
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 4'd1;
            2'b01:   count_next = count_reg - 4'd1;
            default: count_next = count_reg;
        endcase
        // A dropped store outranks a simultaneous clear.
        if (push_attempt & full) begin
            ovf_next = 1'b1;
        end else if (clear_ovf) begin
            ovf_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    baud_next  = BAUD_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_LOAD;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - BW'(1);
                end
            end
            DATA: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_LOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - BW'(1);
                end
            end
            STOP: begin
                if (baud_reg == '0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        baud_next  = BAUD_LOAD;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg - BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= 3'd0;
            shift_reg  <= 8'd0;
            tx_reg     <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 4'd0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKDIV=4, DEPTH=4: reset, single frame,
// back-to-back frames, overflow, address decode and FIFO pointer wrap.
module tb_mmio_uart_tx;

    localparam int TB_DIV   = 4;
    localparam int TB_DEPTH = 4;
    localparam int FRAME    = 10 * TB_DIV;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemtoReg;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] RdData;
    logic        Hit;
    logic        tx;

    int n_checks;
    int n_fails;

    mmio_uart_tx #(
        .BASE   (32'h804),
        .CLKDIV (TB_DIV),
        .DEPTH  (TB_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .RdData    (RdData),
        .Hit       (Hit),
        .tx        (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line levels for one frame, one entry per clock after the pop edge.
    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
        logic [FRAME-1:0] f;
        for (int k = 0; k < FRAME; k++) begin
            int s;
            s = k / TB_DIV;
            if (s == 0)      f[k] = 1'b0;
            else if (s == 9) f[k] = 1'b1;
            else             f[k] = b[s-1];
        end
        return f;
    endfunction

    function automatic logic [7:0] wrap_byte(input int i);
        return 8'((i * 29 + 49) & 255);
    endfunction

    task automatic read_status(output logic [31:0] v);
        MemtoReg = 1'b1;
        DataAdr  = 32'h808;
        #1;
        v        = RdData;
        MemtoReg = 1'b0;
        DataAdr  = 32'h0;
    endtask

    // Called at a falling edge; returns at the falling edge after the capturing rising edge.
    task automatic drive_store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        @(negedge clk);
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
    endtask

    task automatic capture_frame(output logic [FRAME-1:0] f);
        for (int k = 0; k < FRAME; k++) begin
            f[k] = tx;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] st;
        logic [19:0] line;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fails++; $display("FAIL reset_tx: got %b want 1", tx); end
        read_status(st);
        n_checks++;
        if (st !== 32'h02) begin n_fails++; $display("FAIL reset_status: got %h want 00000002", st); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_status(st);
        n_checks++;
        if (st !== 32'h02) begin n_fails++; $display("FAIL release_status: got %h want 00000002", st); end
        $display("reset idle: tx=%b status=%h", tx, st);

        @(negedge clk);
        drive_store(32'h804, 32'h00);
        drive_store(32'h804, 32'h00);
        n_checks++;
        if (tx !== 1'b0) begin n_fails++; $display("FAIL midframe_start: got %b want 0", tx); end
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fails++; $display("FAIL midframe_tx: got %b want 1", tx); end
        read_status(st);
        n_checks++;
        if (st !== 32'h02) begin n_fails++; $display("FAIL midframe_status: got %h want 00000002", st); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            line[k] = tx;
            @(negedge clk);
        end
        n_checks++;
        if (line !== 20'hFFFFF) begin n_fails++; $display("FAIL post_reset_line: got %h want fffff", line); end
        read_status(st);
        n_checks++;
        if (st !== 32'h02) begin n_fails++; $display("FAIL post_reset_status: got %h want 00000002", st); end
        $display("reset midframe: line=%h status=%h", line, st);
    endtask

    task automatic test_single;
        logic [31:0] st;
        logic [FRAME-1:0] f;
        @(negedge clk);
        drive_store(32'h804, 32'hA5);
        read_status(st);
        n_checks++;
        if (st !== 32'h10) begin n_fails++; $display("FAIL single_pushed: got %h want 00000010", st); end
        n_checks++;
        if (tx !== 1'b1) begin n_fails++; $display("FAIL single_pre_tx: got %b want 1", tx); end
        @(negedge clk);
        read_status(st);
        n_checks++;
        if (st !== 32'h06) begin n_fails++; $display("FAIL single_popped: got %h want 00000006", st); end
        capture_frame(f);
        n_checks++;
        if (f !== frame_bits(8'hA5)) begin
            n_fails++; $display("FAIL single_frame: got %h want %h", f, frame_bits(8'hA5));
        end
        read_status(st);
        n_checks++;
        if (st !== 32'h02) begin n_fails++; $display("FAIL single_idle: got %h want 00000002", st); end
        $display("single A5: frame=%h status=%h", f, st);
    endtask

    task automatic test_back_to_back;
        logic [31:0] st;
        logic [FRAME-1:0] f1, f2;
        @(negedge clk);
        drive_store(32'h804, 32'h55);
        drive_store(32'h804, 32'h0F);
        read_status(st);
        n_checks++;
        if (st !== 32'h14) begin n_fails++; $display("FAIL b2b_after_pop: got %h want 00000014", st); end
        capture_frame(f1);
        read_status(st);
        n_checks++;
        if (st !== 32'h06) begin n_fails++; $display("FAIL b2b_second_pop: got %h want 00000006", st); end
        capture_frame(f2);
        n_checks++;
        if (f1 !== frame_bits(8'h55)) begin
            n_fails++; $display("FAIL b2b_frame1: got %h want %h", f1, frame_bits(8'h55));
        end
        n_checks++;
        if (f2 !== frame_bits(8'h0F)) begin
            n_fails++; $display("FAIL b2b_frame2: got %h want %h", f2, frame_bits(8'h0F));
        end
        read_status(st);
        n_checks++;
        if (st !== 32'h02) begin n_fails++; $display("FAIL b2b_idle: got %h want 00000002", st); end
        $display("back-to-back 55,0F: f1=%h f2=%h status=%h", f1, f2, st);
    endtask

    task automatic test_overflow;
        logic [31:0] st;
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            drive_store(32'h804, 32'(i * 17));
        end
        // The first byte leaves on the second store's edge, so four stay buffered and the sixth is lost.
        read_status(st);
        n_checks++;
        if (st !== 32'h4D) begin n_fails++; $display("FAIL ovf_set: got %h want 0000004d", st); end
        @(negedge clk);
        drive_store(32'h808, 32'hF7);
        read_status(st);
        n_checks++;
        if (st !== 32'h4D) begin n_fails++; $display("FAIL ovf_no_clear: got %h want 0000004d", st); end
        @(negedge clk);
        drive_store(32'h808, 32'h08);
        read_status(st);
        n_checks++;
        if (st !== 32'h45) begin n_fails++; $display("FAIL ovf_clear: got %h want 00000045", st); end
        $display("overflow: status after clear=%h", st);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_decode;
        logic [31:0] st;
        DataAdr  = 32'h800;
        MemtoReg = 1'b1;
        #1;
        n_checks++;
        if (Hit !== 1'b0 || RdData !== 32'h0) begin
            n_fails++; $display("FAIL dec_800: hit=%b rd=%h want hit=0 rd=0", Hit, RdData);
        end
        DataAdr = 32'h80C;
        #1;
        n_checks++;
        if (Hit !== 1'b0 || RdData !== 32'h0) begin
            n_fails++; $display("FAIL dec_80C: hit=%b rd=%h want hit=0 rd=0", Hit, RdData);
        end
        DataAdr = 32'h804;
        #1;
        n_checks++;
        if (Hit !== 1'b1 || RdData !== 32'h0) begin
            n_fails++; $display("FAIL dec_804: hit=%b rd=%h want hit=1 rd=0", Hit, RdData);
        end
        DataAdr = 32'h808;
        #1;
        n_checks++;
        if (Hit !== 1'b1 || RdData !== 32'h02) begin
            n_fails++; $display("FAIL dec_808: hit=%b rd=%h want hit=1 rd=2", Hit, RdData);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (RdData !== 32'h02 || tx !== 1'b1) begin
            n_fails++; $display("FAIL dec_load_side_effect: rd=%h tx=%b want rd=2 tx=1", RdData, tx);
        end
        MemtoReg = 1'b0;
        DataAdr  = 32'h0;
        drive_store(32'h800, 32'hAA);
        drive_store(32'h80C, 32'hBB);
        @(negedge clk);
        read_status(st);
        n_checks++;
        if (st !== 32'h02 || tx !== 1'b1) begin
            n_fails++; $display("FAIL dec_stray_store: status=%h tx=%b want 00000002 tx=1", st, tx);
        end
        $display("decode: stray stores ignored, status=%h", st);
    endtask

    task automatic test_wrap;
        logic [31:0] st;
        fork
            begin
                logic [31:0] ps;
                for (int i = 0; i < 3 * TB_DEPTH; i++) begin
                    bit ok;
                    ok = 1'b0;
                    for (int g = 0; g < 2000 && !ok; g++) begin
                        @(negedge clk);
                        MemWrite = 1'b0;
                        read_status(ps);
                        if (ps[0] == 1'b0) begin
                            MemWrite  = 1'b1;
                            DataAdr   = 32'h804;
                            WriteData = {24'b0, wrap_byte(i)};
                            ok        = 1'b1;
                        end
                    end
                    n_checks++;
                    if (!ok) begin n_fails++; $display("FAIL wrap_push_timeout: byte %0d never accepted", i); end
                end
                @(negedge clk);
                MemWrite = 1'b0;
                DataAdr  = 32'h0;
            end
            begin
                logic [FRAME-1:0] f;
                int w;
                w = 0;
                while (tx !== 1'b0 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                n_checks++;
                if (tx !== 1'b0) begin n_fails++; $display("FAIL wrap_start: tx=%b want 0", tx); end
                for (int i = 0; i < 3 * TB_DEPTH; i++) begin
                    capture_frame(f);
                    n_checks++;
                    if (f !== frame_bits(wrap_byte(i))) begin
                        n_fails++; $display("FAIL wrap_frame%0d: got %h want %h", i, f, frame_bits(wrap_byte(i)));
                    end
                    $display("wrap byte %0d: %h", i, wrap_byte(i));
                end
            end
        join
        read_status(st);
        n_checks++;
        if (st !== 32'h02) begin n_fails++; $display("FAIL wrap_idle: got %h want 00000002", st); end
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_decode;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
